// File: rtl/spi_reg_pkg.sv
// Shared frame layout, FSM states and PWM peripheral register map for the SPI register-write master.
package spi_reg_pkg;

    localparam int FRAME_W = 16;
    localparam int WR_BIT  = 15;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic [ADDR_W-1:0] EN_REG_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] EN_REG_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] EN_REG_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] EN_REG_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] PWM_DUTY_CYCLE  = 7'h04;

    function automatic logic [FRAME_W-1:0] make_frame(input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] data);
        logic [FRAME_W-1:0] f;
        f                   = '0;
        f[WR_BIT]           = 1'b1;
        f[WR_BIT-1:DATA_W]  = addr;
        f[DATA_W-1:0]       = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_reg_master_tick_gen.sv
// Half-period tick generator: pulses tick every CLK_DIV cycles while run is high.
// Latency: first tick CLK_DIV cycles after run rises; counter parked at CLK_DIV-1 while idle.
// Backpressure: none; free-running while run is asserted.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    // Reload happens on the same edge the tick is consumed, so zero is never decremented.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || cnt == 8'd0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tick = run && (cnt == 8'd0);

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 register-write master: one 16-bit write frame {1, addr, data} per accepted request.
// Latency: ncs low the cycle after acceptance; done at +33*CLK_DIV; ready again at +34*CLK_DIV.
// Backpressure: cmd_ready only in IDLE; requests while busy are dropped, never queued.
module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              done,
    output logic              sclk,
    output logic              copi,
    output logic              ncs
);

    state_t             state;
    logic [FRAME_W-2:0] shreg;
    logic [3:0]         bit_cnt;
    logic               tick;
    logic [FRAME_W-1:0] frame_next;

    assign frame_next = make_frame(cmd_addr, cmd_data);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (state != ST_IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sclk      <= 1'b0;
            ncs       <= 1'b1;
            copi      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        // MSB goes straight to copi; the rest waits in the shifter.
                        copi      <= frame_next[FRAME_W-1];
                        shreg     <= frame_next[FRAME_W-2:0];
                        ncs       <= 1'b0;
                        cmd_ready <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        sclk  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                state <= ST_HOLD;
                            end else begin
                                copi    <= shreg[FRAME_W-2];
                                shreg   <= {shreg[FRAME_W-3:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        ncs   <= 1'b1;
                        copi  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
